// File: rtl/alpharetz_uart_rx.sv
// alpharetz_uart_rx: UART receive stage. Synchronises the serial line, samples
// start/data/parity/stop at bit midpoints and hands each word to the CPU side
// on a valid/ready handshake with parity/frame error flags and overrun pulse.
module alpharetz_uart_rx #(
  parameter int UART_DATA_WIDTH = 8,
  parameter int UART_CLK_RATIO  = 16
) (
  input  logic                       sys_clk,
  input  logic                       async_rst_n,
  input  logic                       sys_clk_en,
  input  logic                       uart_rx,
  output logic [UART_DATA_WIDTH-1:0] rx_data,
  output logic                       rx_parity_err,
  output logic                       rx_frame_err,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic                       overrun,
  output logic                       busy
);

  localparam int HALF = UART_CLK_RATIO / 2;
  localparam int TW   = $clog2(UART_CLK_RATIO);
  localparam int BW   = $clog2(UART_DATA_WIDTH) + 1;

  localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
  localparam logic [TW-1:0] T_LAST = TW'(UART_CLK_RATIO - 1);
  localparam logic [BW-1:0] B_LAST = BW'(UART_DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } state_t;

  state_t                     state, state_next;
  logic                       rx_meta, rxs;
  logic [TW-1:0]              timer;
  logic [BW-1:0]              bit_idx;
  logic [UART_DATA_WIDTH-1:0] shreg;
  logic                       parity_bit;
  logic                       sample;
  logic                       deliver;

  assign busy = (state != S_IDLE);

  // Two-flop synchroniser on the asynchronous line, idling high.
  always_ff @(posedge sys_clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else if (sys_clk_en) begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge sys_clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state <= S_IDLE;
    end else if (sys_clk_en) begin
      state <= state_next;
    end
  end

  // Next-state decode; sample/deliver strobes mark the bit midpoints.
  always_comb begin
    state_next = state;
    sample     = (timer == T_LAST);
    deliver    = 1'b0;
    case (state)
      S_IDLE:       if (!rxs) state_next = S_START;
      S_START:      if (timer == T_HALF) state_next = rxs ? S_IDLE : S_DATA;
      S_DATA:       if (sample && (bit_idx == B_LAST)) state_next = S_PARITY;
      S_PARITY:     if (sample) state_next = S_STOP;
      S_STOP: begin
        if (sample) begin
          deliver    = 1'b1;
          state_next = rxs ? S_IDLE : S_BREAK_WAIT;
        end
      end
      S_BREAK_WAIT: if (rxs) state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  // Bit timer and bit index; both restart on every state change, and the
  // timer also wraps each bit period while staying in DATA.
  always_ff @(posedge sys_clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      timer   <= '0;
      bit_idx <= '0;
    end else if (sys_clk_en) begin
      if (state_next != state) begin
        timer   <= '0;
        bit_idx <= '0;
      end else begin
        timer <= sample ? '0 : timer + TW'(1);
        if ((state == S_DATA) && sample) bit_idx <= bit_idx + BW'(1);
      end
    end
  end

  // Data shift register (LSB first into the MSB end) and parity capture.
  always_ff @(posedge sys_clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      shreg      <= '0;
      parity_bit <= 1'b0;
    end else if (sys_clk_en) begin
      if ((state == S_DATA) && sample)
        shreg <= (shreg >> 1) | (UART_DATA_WIDTH'(rxs) << (UART_DATA_WIDTH - 1));
      if ((state == S_PARITY) && sample)
        parity_bit <= rxs;
    end
  end

  // Output word/flags with handshake; an accept in the delivery cycle frees
  // the slot so the new frame loads instead of overrunning.
  always_ff @(posedge sys_clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_valid      <= 1'b0;
      overrun       <= 1'b0;
    end else if (sys_clk_en) begin
      overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data       <= shreg;
          rx_parity_err <= (^shreg) ^ parity_bit;
          rx_frame_err  <= !rxs;
          rx_valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alpharetz_uart_rx.sv
// Testbench for alpharetz_uart_rx: table of directed frames plus hand-written
// sequences for glitch, overrun, simultaneous accept, break and mid-frame reset.
module tb_alpharetz_uart_rx;

  localparam int R   = 16;
  localparam int LAT = R / 2 + 10 * R + 3;  // pin falling edge to rx_valid

  logic       sys_clk = 1'b0;
  logic       async_rst_n;
  logic       sys_clk_en;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_valid;
  logic       rx_ready;
  logic       overrun;
  logic       busy;

  int tests   = 0;
  int failed  = 0;
  int ovr_cnt = 0;
  int lat;
  int ob;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;

  vec_t vecs[7];

  alpharetz_uart_rx #(
    .UART_DATA_WIDTH(8),
    .UART_CLK_RATIO (R)
  ) dut (
    .sys_clk      (sys_clk),
    .async_rst_n  (async_rst_n),
    .sys_clk_en   (sys_clk_en),
    .uart_rx      (uart_rx),
    .rx_data      (rx_data),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .overrun      (overrun),
    .busy         (busy)
  );

  // Free-running clock.
  always #5 sys_clk = ~sys_clk;

  // Count overrun pulse cycles, sampled away from the active edge.
  always @(negedge sys_clk) if (overrun === 1'b1) ovr_cnt++;

  // Run-time bound.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    uart_rx = b;
    tick(R);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    uart_rx = 1'b1;
  endtask

  // Sends a frame while counting cycles to rx_valid; with acc set, rx_ready
  // is raised exactly for the delivery edge instead.
  task automatic run_frame(input logic [7:0] d, input logic p, input logic s,
                           input bit acc, output int latency);
    int l;
    l = 0;
    fork
      send_frame(d, p, s);
      begin
        for (int n = 1; n <= 11 * R; n++) begin
          if (acc && n == LAT) rx_ready = 1'b1;
          @(posedge sys_clk);
          #1;
          if (acc && n == LAT) rx_ready = 1'b0;
          if (!acc && l == 0 && rx_valid === 1'b1) l = n;
        end
      end
    join
    latency = l;
  endtask

  task automatic accept(input string name);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check(name, rx_valid, 0);
  endtask

  initial begin
    vecs[0] = '{d: 8'hA5, p: 1'b0, s: 1'b1, ed: 8'hA5, ep: 1'b0, ef: 1'b0};
    vecs[1] = '{d: 8'h01, p: 1'b0, s: 1'b1, ed: 8'h01, ep: 1'b1, ef: 1'b0};
    vecs[2] = '{d: 8'h80, p: 1'b1, s: 1'b1, ed: 8'h80, ep: 1'b0, ef: 1'b0};
    vecs[3] = '{d: 8'hFF, p: 1'b0, s: 1'b1, ed: 8'hFF, ep: 1'b0, ef: 1'b0};
    vecs[4] = '{d: 8'h5A, p: 1'b1, s: 1'b1, ed: 8'h5A, ep: 1'b1, ef: 1'b0};
    vecs[5] = '{d: 8'h0F, p: 1'b0, s: 1'b0, ed: 8'h0F, ep: 1'b0, ef: 1'b1};
    vecs[6] = '{d: 8'h37, p: 1'b0, s: 1'b1, ed: 8'h37, ep: 1'b1, ef: 1'b0};

    sys_clk_en  = 1'b1;
    uart_rx     = 1'b1;
    rx_ready    = 1'b0;
    async_rst_n = 1'b0;
    tick(3);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_parity_err", rx_parity_err, 0);
    check("reset_frame_err", rx_frame_err, 0);
    check("reset_overrun", overrun, 0);
    check("reset_busy", busy, 0);
    async_rst_n = 1'b1;
    tick(4);

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      ob = ovr_cnt;
      run_frame(vecs[i].d, vecs[i].p, vecs[i].s, 1'b0, lat);
      check($sformatf("v%0d_latency", i), lat, LAT);
      tick(20);
      check($sformatf("v%0d_valid_held", i), rx_valid, 1);
      check($sformatf("v%0d_data", i), rx_data, vecs[i].ed);
      check($sformatf("v%0d_parity_err", i), rx_parity_err, vecs[i].ep);
      check($sformatf("v%0d_frame_err", i), rx_frame_err, vecs[i].ef);
      check($sformatf("v%0d_no_overrun", i), ovr_cnt - ob, 0);
      accept($sformatf("v%0d_accept", i));
      tick(2 * R);
    end

    // Short glitch: START aborts at midpoint.
    uart_rx = 1'b0;
    tick(4);
    check("glitch_busy_high", busy, 1);
    uart_rx = 1'b1;
    tick(20);
    check("glitch_busy_low", busy, 0);
    check("glitch_no_valid", rx_valid, 0);
    tick(200);
    check("glitch_no_valid_late", rx_valid, 0);

    // Back-to-back frames without accept: second one overruns.
    ob = ovr_cnt;
    run_frame(8'h11, 1'b0, 1'b1, 1'b0, lat);
    run_frame(8'h22, 1'b0, 1'b1, 1'b0, lat);
    check("ovr_pulse_count", ovr_cnt - ob, 1);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data_kept", rx_data, 8'h11);
    accept("ovr_accept");
    tick(2 * R);

    // Accept coinciding with delivery: new word loads, no overrun.
    run_frame(8'h33, 1'b0, 1'b1, 1'b0, lat);
    ob = ovr_cnt;
    run_frame(8'h44, 1'b0, 1'b1, 1'b1, lat);
    check("simul_valid", rx_valid, 1);
    check("simul_data", rx_data, 8'h44);
    check("simul_no_overrun", ovr_cnt - ob, 0);
    accept("simul_accept");
    tick(2 * R);

    // Line held low: one framing-error word, then wait for idle.
    uart_rx = 1'b0;
    tick(20 * R);
    check("break_valid", rx_valid, 1);
    check("break_data", rx_data, 0);
    check("break_frame_err", rx_frame_err, 1);
    check("break_parity_err", rx_parity_err, 0);
    check("break_busy", busy, 1);
    accept("break_accept");
    tick(3 * R);
    check("break_no_retrigger", rx_valid, 0);
    check("break_still_busy", busy, 1);
    uart_rx = 1'b1;
    tick(4);
    check("break_exit_idle", busy, 0);
    tick(R);
    run_frame(8'h3C, 1'b0, 1'b1, 1'b0, lat);
    check("after_break_latency", lat, LAT);
    check("after_break_data", rx_data, 8'h3C);
    check("after_break_parity_err", rx_parity_err, 0);
    check("after_break_frame_err", rx_frame_err, 0);
    accept("after_break_accept");
    tick(2 * R);

    // Reset in the middle of data bit 4 of 0xFF.
    uart_rx = 1'b0;
    tick(R);
    uart_rx = 1'b1;
    tick(4 * R + R / 2);
    check("midreset_busy_before", busy, 1);
    async_rst_n = 1'b0;
    #1;
    check("midreset_data", rx_data, 0);
    check("midreset_valid", rx_valid, 0);
    check("midreset_busy", busy, 0);
    check("midreset_parity_err", rx_parity_err, 0);
    check("midreset_frame_err", rx_frame_err, 0);
    tick(2);
    async_rst_n = 1'b1;
    tick(R);
    check("midreset_no_frame", rx_valid, 0);
    run_frame(8'h5A, 1'b0, 1'b1, 1'b0, lat);
    check("postreset_latency", lat, LAT);
    check("postreset_data", rx_data, 8'h5A);
    check("postreset_parity_err", rx_parity_err, 0);
    check("postreset_frame_err", rx_frame_err, 0);
    accept("postreset_accept");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/alpharetz_uart_rx.md
# alpharetz_uart_rx

Serial receive stage that consumes the frame format produced by the UART transmitter and delivers parallel words to the CPU side. Each frame is a start bit (0), `UART_DATA_WIDTH` data bits LSB first, an even-parity bit (XOR of the data bits), and a stop bit (1). The block synchronises the asynchronous line and samples each bit at its midpoint. It presents each received word with its error flags on a valid/ready handshake and reports overruns.

## Interface
- `UART_DATA_WIDTH`, 8, data bits per frame (≥1)
- `UART_CLK_RATIO`, 16, enabled `sys_clk` cycles per bit; must be even and ≥4; `HALF = UART_CLK_RATIO/2`
- `sys_clk`  input  1  system clock; one clock domain only
- `async_rst_n`  input  1  reset; one clock, reset is asynchronous and active-low
- `sys_clk_en`  input  1  global enable; when low, all state including the synchroniser and handshake holds
- `uart_rx`  input  1  serial line from device; asynchronous; idles high
- `rx_data`  output  UART_DATA_WIDTH  received word; stable while `rx_valid`=1
- `rx_parity_err`  output  1  parity mismatch for the word in `rx_data`
- `rx_frame_err`  output  1  stop bit sampled 0 for the word in `rx_data`
- `rx_valid`  output  1  word available
- `rx_ready`  input  1  CPU accepts the word
- `overrun`  output  1  one-cycle pulse; a completed frame was dropped
- `busy`  output  1  high in every state except IDLE

## Operation
- Synchroniser: two flops on `uart_rx`, reset to 1. All logic uses the second-flop output `rxs`.
- Bit-timer counter, width `$clog2(UART_CLK_RATIO)`. Bit-index counter, width `$clog2(UART_DATA_WIDTH)+1`. Both clear on every state entry.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - IDLE: `rxs`=0 → START.
  - START: at timer = HALF-1, if `rxs`=0 → DATA, otherwise → IDLE (glitch rejected, nothing reported).
  - DATA: at timer = UART_CLK_RATIO-1, shift `rxs` into the MSB of the shift register (right shift, so the LSB ends at bit 0) and increment the bit index. After `UART_DATA_WIDTH` samples → PARITY.
  - PARITY: at timer = UART_CLK_RATIO-1, capture `rxs` as the parity bit → STOP.
  - STOP: at timer = UART_CLK_RATIO-1, sample the stop bit and deliver the frame. If stop=1 → IDLE. If stop=0 → BREAK_WAIT.
  - BREAK_WAIT: `rxs`=1 → IDLE. This prevents a held-low line from retriggering.
- Delivery:
  - `rx_parity_err` = (^data) XOR parity bit. `rx_frame_err` = !stop.
  - If `rx_valid`=0, load `rx_data` and both flags, and set `rx_valid`.
  - If `rx_valid`=1, hold the output registers, drop the new frame, and pulse `overrun`.
- Handshake: `rx_valid` clears on the cycle after `rx_valid & rx_ready`. The receiver never stalls the line.
- Simultaneous delivery and accept in the same cycle: the accept completes the old word and the new frame loads. `rx_valid` stays 1 and no overrun is reported.
- Reset, including mid-frame: FSM → IDLE, counters → 0, synchroniser → 1. The partial frame is discarded.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `rx_parity_err`=0, `rx_frame_err`=0, `overrun`=0, `busy`=0.
- Synchroniser latency: 2 enabled cycles.
- From the first cycle `rxs`=0 in IDLE to `rx_valid` high: HALF + (UART_DATA_WIDTH+2)·UART_CLK_RATIO + 1 enabled cycles. With the defaults this is 169 cycles, or 171 from the pin.
- Return to IDLE happens at the stop-bit midpoint. A back-to-back start edge arriving half a bit later is detected.
- `busy` rises the cycle after START entry and falls the cycle after the stop-bit sample (or on BREAK_WAIT exit).
- `sys_clk_en`=0 for any number of cycles stretches all timing without losing state.

## Test plan
- Send 0xA5 with parity 0 and stop 1 (defaults) → `rx_data`=0xA5, both error flags 0, `rx_valid` rises 171 cycles after the pin falling edge and holds until `rx_ready`.
- Send 0x01 with parity bit 0 → `rx_data`=0x01, `rx_parity_err`=1, `rx_frame_err`=0.
- Drive the line low for 4 cycles, then high → START aborts at midpoint, `rx_valid` stays 0, `busy` returns to 0.
- Send two frames, 0x11 then 0x22, with `rx_ready`=0 → `rx_data`=0x11 retained, one `overrun` pulse at the second stop sample. Raise `rx_ready` → `rx_valid` clears.
- Hold the line low for 20 bit times → one word 0x00 with `rx_frame_err`=1 and `rx_parity_err`=0. No further frames until the line goes high, then a frame 0x3C is received cleanly.
- Assert `async_rst_n` low during DATA bit 4 of 0xFF, then release → all outputs at reset values. The next full frame 0x5A is received correctly.
